axi_vga_stream_pixel: RTL and testbench



---
 rtl/axi_vga_stream_pixel.sv | 156 +++++++++++++++
 tb/tb_axi_vga_stream_pixel.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_vga_stream_pixel.sv
// Purpose : unpacks AXIDataWidth-bit stream words into RGB565 pixels and generates VGA raster timing.
// Latency : outputs are registered, one cycle behind the raster counters; sync/de/RGB/frame_start stay aligned.
// Backpressure: TREADY only when the word buffer is empty or its last pixel is being consumed; a refill can happen with no bubble.
//
// Ports:
//   clk_i, rst_ni        pixel clock, asynchronous active-low reset
//   enable_i             run enable; low holds the raster at the origin and blanks the outputs
//   S_AXIS_TVALID/TREADY/TDATA  word stream from the clock-crossing FIFO read side, pixel 0 in the LSBs
//   hsync_o, vsync_o, de_o, red_o, green_o, blue_o  VGA pin outputs
//   frame_start_o        one-cycle pulse aligned with the first visible pixel of a frame
//   underflow_o          sticky: a visible pixel slot found no data buffered
module axi_vga_stream_pixel #(
    parameter int   AXIDataWidth = 64,
    parameter int   PixelWidth   = 16,
    parameter int   HVis         = 640,
    parameter int   HFront       = 16,
    parameter int   HSync        = 96,
    parameter int   HBack        = 48,
    parameter int   VVis         = 480,
    parameter int   VFront       = 10,
    parameter int   VSync        = 2,
    parameter int   VBack        = 33,
    parameter logic HSyncPol     = 1'b0,
    parameter logic VSyncPol     = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    input  logic [AXIDataWidth-1:0] S_AXIS_TDATA,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    de_o,
    output logic [4:0]              red_o,
    output logic [5:0]              green_o,
    output logic [4:0]              blue_o,
    output logic                    frame_start_o,
    output logic                    underflow_o
);

    localparam int PPW  = AXIDataWidth / PixelWidth;
    localparam int HTot = HVis + HFront + HSync + HBack;
    localparam int VTot = VVis + VFront + VSync + VBack;
    localparam int HW   = $clog2(HTot);
    localparam int VW   = $clog2(VTot);
    localparam int IdxW = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [HW-1:0]   HLast   = HW'(HTot - 1);
    localparam logic [VW-1:0]   VLast   = VW'(VTot - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(PPW - 1);

    logic [HW-1:0]           h_cnt;
    logic [VW-1:0]           v_cnt;
    logic [31:0]             h_ext;
    logic [31:0]             v_ext;
    logic [AXIDataWidth-1:0] word_buf;
    logic                    buf_valid;
    logic [IdxW-1:0]         idx;
    logic [PixelWidth-1:0]   pix;
    logic                    visible;
    logic                    hs_act;
    logic                    vs_act;
    logic                    consume;
    logic                    idx_last;
    logic                    take;

    // Widen the counters once so every region compare is done at 32 bits;
    // this also keeps sync windows that end exactly at the total well defined.
    assign h_ext = 32'(h_cnt);
    assign v_ext = 32'(v_cnt);

    assign visible  = (h_ext < 32'(HVis)) && (v_ext < 32'(VVis));
    assign hs_act   = (h_ext >= 32'(HVis + HFront)) && (h_ext < 32'(HVis + HFront + HSync));
    assign vs_act   = (v_ext >= 32'(VVis + VFront)) && (v_ext < 32'(VVis + VFront + VSync));
    assign consume  = visible && buf_valid;
    assign idx_last = (idx == IdxLast);

    assign S_AXIS_TREADY = enable_i && (!buf_valid || (consume && idx_last));
    assign take          = S_AXIS_TVALID && S_AXIS_TREADY;

    // Current pixel out of the held word, LSB pixel first.
    always_comb begin
        pix = '0;
        for (int i = 0; i < PPW; i++) begin
            if (idx == IdxW'(i)) begin
                pix = word_buf[i*PixelWidth +: PixelWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            word_buf      <= '0;
            buf_valid     <= 1'b0;
            idx           <= '0;
            hsync_o       <= ~HSyncPol;
            vsync_o       <= ~VSyncPol;
            de_o          <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else if (!enable_i) begin
            // Held at the origin; any partially consumed word is dropped.
            h_cnt         <= '0;
            v_cnt         <= '0;
            buf_valid     <= 1'b0;
            idx           <= '0;
            hsync_o       <= ~HSyncPol;
            vsync_o       <= ~VSyncPol;
            de_o          <= 1'b0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            if (h_cnt == HLast) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VLast) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end

            // A take only happens with an empty buffer or on the last pixel,
            // so loading the new word always restarts at pixel 0.
            if (take) begin
                word_buf  <= S_AXIS_TDATA;
                buf_valid <= 1'b1;
                idx       <= '0;
            end else if (consume) begin
                if (idx_last) begin
                    idx       <= '0;
                    buf_valid <= 1'b0;
                end else begin
                    idx <= idx + IdxW'(1);
                end
            end

            hsync_o       <= hs_act ? HSyncPol : ~HSyncPol;
            vsync_o       <= vs_act ? VSyncPol : ~VSyncPol;
            de_o          <= visible;
            red_o         <= consume ? pix[15:11] : 5'd0;
            green_o       <= consume ? pix[10:5]  : 6'd0;
            blue_o        <= consume ? pix[4:0]   : 5'd0;
            frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
            // Visible slot with nothing buffered: black pixel, slot not consumed.
            underflow_o   <= underflow_o || (visible && !buf_valid);
        end
    end

endmodule

// File: tb/tb_axi_vga_stream_pixel.sv
// Purpose : scoreboard bench for axi_vga_stream_pixel on a reduced 14x7 raster.
// Latency : expected raster timing is derived from cycles elapsed since enable; pixels are popped per de_o cycle.
// Backpressure: the word source holds TDATA until TVALID && TREADY is seen at a clock edge.
module tb_axi_vga_stream_pixel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        src_en;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [63:0] tdata = '0;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        frame_start;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [63:0] src_q[$];
    logic [15:0] exp_q[$];
    int          hs_cnt = 0;
    bit          hs = 1'b0;

    bit en_edge = 1'b0;
    int run_cnt = 0;
    int pos     = 0;

    always #5 clk = ~clk;

    axi_vga_stream_pixel #(
        .AXIDataWidth(64), .PixelWidth(16),
        .HVis(8), .HFront(2), .HSync(2), .HBack(2),
        .VVis(4), .VFront(1), .VSync(1), .VBack(1),
        .HSyncPol(1'b0), .VSyncPol(1'b0)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .enable_i(enable),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .S_AXIS_TDATA(tdata),
        .hsync_o(hsync),
        .vsync_o(vsync),
        .de_o(de),
        .red_o(red),
        .green_o(green),
        .blue_o(blue),
        .frame_start_o(frame_start),
        .underflow_o(underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic refresh();
        tvalid = src_en && (src_q.size() != 0);
        tdata  = (src_q.size() != 0) ? src_q[0] : 64'd0;
    endtask

    // Word source: a FIFO read side that pops on an accepted handshake.
    always begin
        @(negedge clk);
        #2;
        refresh();
        #2;
        hs = tvalid && tready;
        @(posedge clk);
        #1;
        if (hs) begin
            void'(src_q.pop_front());
            hs_cnt++;
        end
        refresh();
    end

    // Raster position the DUT should have registered on this edge.
    always @(posedge clk) begin
        en_edge = rst_n && enable;
        if (en_edge) begin
            pos = run_cnt;
            run_cnt++;
        end else begin
            run_cnt = 0;
        end
    end

    // Monitor: timing against the raster model, pixels against the scoreboard.
    always @(negedge clk) begin
        int h;
        int v;
        logic [15:0] e;
        if (en_edge) begin
            h = pos % 14;
            v = (pos / 14) % 7;
            check("hsync", 32'(hsync), 32'(!(h >= 10 && h < 12)));
            check("vsync", 32'(vsync), 32'(v != 5));
            check("de", 32'(de), 32'(h < 8 && v < 4));
            check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
            if (de) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_extra: got %0h expected no visible pixel at pos %0d", {red, green, blue}, pos);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'({red, green, blue}), 32'(e));
                end
            end
        end else begin
            check("idle_outputs", 32'({hsync, vsync, de, red, green, blue, frame_start, underflow, tready}),
                  32'({1'b1, 1'b1, 20'd0}));
        end
    end

    initial begin
        logic [63:0] w;
        int          hs_base;

        rst_n  = 1'b0;
        enable = 1'b0;
        src_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // One frame with no data: every visible slot is a black underflow pixel.
        for (int i = 0; i < 32; i++) exp_q.push_back(16'h0000);
        enable = 1'b1;
        tick();
        check("underflow_first_visible", 32'(underflow), 32'd1);
        repeat (97) tick();
        check("underflow_held", 32'(underflow), 32'd1);
        check("p1_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        enable = 1'b0;
        repeat (2) tick();
        check("underflow_cleared", 32'(underflow), 32'd0);

        // Three frames of continuous data; the first slot underflows while the first word loads.
        for (int k = 0; k < 24; k++) begin
            for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(4*k + j + 1);
            src_q.push_back(w);
        end
        exp_q.push_back(16'h0000);
        for (int p = 1; p <= 95; p++) exp_q.push_back(16'(p));
        hs_base = hs_cnt;
        src_en  = 1'b1;
        tick();
        check("tready_while_disabled", 32'(tready), 32'd0);
        enable = 1'b1;
        for (int n = 0; n < 294; n++) begin
            tick();
            if (n == 9)  check("tready_hblank", 32'(tready), 32'd0);
            if (n == 60) check("tready_vblank", 32'(tready), 32'd0);
        end
        check("p2_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("p2_source_drained", 32'(src_q.size()), 32'd0);
        check("p2_handshakes", 32'(hs_cnt - hs_base), 32'd24);
        enable = 1'b0;
        src_en = 1'b0;
        repeat (2) tick();

        // Colour mapping plus a 4-slot starvation at the start of the frame,
        // then drop enable with the raster at h=5 of line 1.
        w = {16'h1234, 16'h001F, 16'h07E0, 16'hF800};
        src_q.push_back(w);
        w = 64'h0008_0007_0006_0005;
        src_q.push_back(w);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0000);
        exp_q.push_back(16'hF800);
        exp_q.push_back(16'h07E0);
        exp_q.push_back(16'h001F);
        exp_q.push_back(16'h1234);
        for (int p = 5; p <= 8; p++) exp_q.push_back(16'(p));
        exp_q.push_back(16'h0000);
        hs_base = hs_cnt;
        enable  = 1'b1;
        repeat (3) tick();
        src_en = 1'b1;
        repeat (16) tick();
        check("underflow_sticky", 32'(underflow), 32'd1);
        check("p3_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("p3_handshakes", 32'(hs_cnt - hs_base), 32'd2);
        enable = 1'b0;
        tick();
        check("underflow_after_disable", 32'(underflow), 32'd0);

        // Re-enable: the first word loads during the first visible slot.
        src_q.push_back(64'h0C04_0C03_0C02_0C01);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0C01);
        exp_q.push_back(16'h0C02);
        exp_q.push_back(16'h0C03);
        exp_q.push_back(16'h0C04);
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h0000);
        tick();
        enable = 1'b1;
        repeat (14) tick();
        check("p4_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("p4_source_drained", 32'(src_q.size()), 32'd0);
        enable = 1'b0;
        src_en = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
